// File: rtl/player_bullet_if.sv
// Combat-side interface between the player tank logic and its bullet launcher.
// Optional macro: PLAYER_BULLET_SCORE_EN adds hit_count (enemy kills credited to the bullet).
//   master : tank / game logic (drives fire and tank state, reads bullet state)
//   slave  : player_bullet (reads fire and tank state, drives bullet state)
// Signals:
//   fire           debounced fire button level
//   tank_dir       {up,down,left,right} one-hot facing
//   x_tank/y_tank  tank left/top edge
//   tank_detroyed  player tank destroyed
//   enemy_hit      OR of all enemies' destroyed flags
//   brick_hit      per-brick overlap with the bullet
//   x_bullet/y_bullet  bullet left/top edge, parked when inactive
//   bullet_active  bullet in flight
//   shot_pulse     one-cycle pulse per launch
//   hit_count      saturating enemy-hit score (macro only)
interface player_bullet_if #(
  parameter int unsigned NUMBER_OF_BRICK = 100
);
  logic                       fire;
  logic [3:0]                 tank_dir;
  logic [9:0]                 x_tank;
  logic [9:0]                 y_tank;
  logic                       tank_detroyed;
  logic                       enemy_hit;
  logic [NUMBER_OF_BRICK-1:0] brick_hit;
  logic [9:0]                 x_bullet;
  logic [9:0]                 y_bullet;
  logic                       bullet_active;
  logic                       shot_pulse;
`ifdef PLAYER_BULLET_SCORE_EN
  logic [7:0]                 hit_count;

  modport master (
    output fire, tank_dir, x_tank, y_tank, tank_detroyed, enemy_hit, brick_hit,
    input  x_bullet, y_bullet, bullet_active, shot_pulse, hit_count
  );

  modport slave (
    input  fire, tank_dir, x_tank, y_tank, tank_detroyed, enemy_hit, brick_hit,
    output x_bullet, y_bullet, bullet_active, shot_pulse, hit_count
  );
`else
  modport master (
    output fire, tank_dir, x_tank, y_tank, tank_detroyed, enemy_hit, brick_hit,
    input  x_bullet, y_bullet, bullet_active, shot_pulse
  );

  modport slave (
    input  fire, tank_dir, x_tank, y_tank, tank_detroyed, enemy_hit, brick_hit,
    output x_bullet, y_bullet, bullet_active, shot_pulse
  );
`endif
endinterface

// File: rtl/player_bullet.sv
// Player-tank bullet launcher. Latches a fire press, launches a 4x4 bullet from the tank centre
// in the facing direction, moves it once per refresh_tick and retires it on wall, brick, enemy
// hit or tank destruction, followed by a cooldown period.
// Optional macro: PLAYER_BULLET_SCORE_EN adds the saturating hit_count score on the interface.
// Ports:
//   clk_50MHz     system clock
//   reset         synchronous active-high reset
//   x, y          current VGA pixel
//   refresh_tick  one-cycle frame strobe; all bullet state advances only on it
//   bus           player_bullet_if.slave (tank inputs, bullet outputs)
//   bullet_on     pixel (x,y) lies inside the active bullet
module player_bullet #(
  parameter int unsigned NUMBER_OF_BRICK = 100,
  parameter int unsigned BULLET_SPEED    = 4,
  parameter int unsigned X_MIN           = 28,
  parameter int unsigned X_MAX           = 607,
  parameter int unsigned Y_MIN           = 28,
  parameter int unsigned Y_MAX           = 447,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned PARK_POS        = 1020
) (
  input  logic            clk_50MHz,
  input  logic            reset,
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  input  logic            refresh_tick,
  player_bullet_if.slave  bus,
  output logic            bullet_on
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLYING   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam logic [9:0] STEP      = 10'(BULLET_SPEED);
  localparam logic [9:0] PARK      = 10'(PARK_POS);
  localparam logic [9:0] X_LO      = 10'(X_MIN + BULLET_SPEED);
  localparam logic [9:0] X_HI      = 10'(X_MAX - BULLET_SPEED);
  localparam logic [9:0] Y_LO      = 10'(Y_MIN + BULLET_SPEED);
  localparam logic [9:0] Y_HI      = 10'(Y_MAX - BULLET_SPEED);
  localparam logic [9:0] CENTRE    = 10'd14;
  // Zero frames still spends one tick in COOLDOWN before IDLE.
  localparam logic [7:0] COOL_LOAD = (COOLDOWN_FRAMES == 0) ? 8'd0 : 8'(COOLDOWN_FRAMES - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [3:0] dir_q, dir_d;
  logic [7:0] cool_cnt_q, cool_cnt_d;
  logic       fire_pending_q, fire_pending_d;
  logic       fire_q;
  logic       shot_pulse_q;

  logic [NUMBER_OF_BRICK-1:0] brick_hit;
  logic       fire_rise;
  logic       dir_onehot;
  logic       launch;
  logic       retire;

  assign brick_hit  = bus.brick_hit;
  assign fire_rise  = bus.fire & ~fire_q;
  assign dir_onehot = (bus.tank_dir != 4'd0) && ((bus.tank_dir & (bus.tank_dir - 4'd1)) == 4'd0);

`ifdef PLAYER_BULLET_SCORE_EN
  logic [7:0] hit_count_q, hit_count_d;
  logic       score_hit;
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_d      = dir_q;
    cool_cnt_d = cool_cnt_q;
    launch     = 1'b0;
    retire     = 1'b0;
`ifdef PLAYER_BULLET_SCORE_EN
    score_hit  = 1'b0;
`endif

    if (refresh_tick) begin
      case (state_q)
        IDLE: begin
          if (fire_pending_q && !bus.tank_detroyed && dir_onehot) begin
            launch  = 1'b1;
            x_d     = bus.x_tank + CENTRE;
            y_d     = bus.y_tank + CENTRE;
            dir_d   = bus.tank_dir;
            state_d = FLYING;
          end
        end
        FLYING: begin
          if (bus.tank_detroyed || bus.enemy_hit || (|brick_hit)) begin
            retire = 1'b1;
`ifdef PLAYER_BULLET_SCORE_EN
            score_hit = bus.enemy_hit;
`endif
          end else begin
            // Bound checks come before the step so the 10-bit positions never wrap.
            unique case (dir_q)
              DIR_UP:    if (y_q < Y_LO) retire = 1'b1; else y_d = y_q - STEP;
              DIR_DOWN:  if (y_q > Y_HI) retire = 1'b1; else y_d = y_q + STEP;
              DIR_LEFT:  if (x_q < X_LO) retire = 1'b1; else x_d = x_q - STEP;
              DIR_RIGHT: if (x_q > X_HI) retire = 1'b1; else x_d = x_q + STEP;
              default:   retire = 1'b1;
            endcase
          end
        end
        COOLDOWN: begin
          if (cool_cnt_q == 8'd0) state_d = IDLE;
          else                    cool_cnt_d = cool_cnt_q - 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (retire) begin
      x_d        = PARK;
      y_d        = PARK;
      state_d    = COOLDOWN;
      cool_cnt_d = COOL_LOAD;
    end

    // Presses outside IDLE are dropped rather than queued.
    fire_pending_d = fire_pending_q;
    if (refresh_tick && bus.tank_detroyed) fire_pending_d = 1'b0;
    else if (launch)                       fire_pending_d = 1'b0;
    else if (fire_rise && state_q == IDLE) fire_pending_d = 1'b1;

`ifdef PLAYER_BULLET_SCORE_EN
    hit_count_d = hit_count_q;
    if (score_hit && hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
`endif
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q        <= IDLE;
      x_q            <= PARK;
      y_q            <= PARK;
      dir_q          <= 4'd0;
      cool_cnt_q     <= 8'd0;
      fire_pending_q <= 1'b0;
      fire_q         <= 1'b0;
      shot_pulse_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      dir_q          <= dir_d;
      cool_cnt_q     <= cool_cnt_d;
      fire_pending_q <= fire_pending_d;
      fire_q         <= bus.fire;
      shot_pulse_q   <= launch;
    end
  end

`ifdef PLAYER_BULLET_SCORE_EN
  always_ff @(posedge clk_50MHz) begin
    if (reset) hit_count_q <= 8'd0;
    else       hit_count_q <= hit_count_d;
  end
  assign bus.hit_count = hit_count_q;
`endif

  assign bus.x_bullet      = x_q;
  assign bus.y_bullet      = y_q;
  assign bus.bullet_active = (state_q == FLYING);
  assign bus.shot_pulse    = shot_pulse_q;

  assign bullet_on = (state_q == FLYING) &&
                     ({1'b0, x} >= {1'b0, x_q}) && ({1'b0, x} <= ({1'b0, x_q} + 11'd3)) &&
                     ({1'b0, y} >= {1'b0, y_q}) && ({1'b0, y} <= ({1'b0, y_q} + 11'd3));

endmodule
